varredura_polinomio: RTL and testbench
======================================

Name: varredura_polinomio

Overview:
- Upstream sequencer and downstream collector for the polynomial datapath core (`controle` + `operativo` pair).
- Takes a sweep description: start X, step, point count, coefficients A/B/C.
- Drives the core's `X`/`A`/`B`/`C`/`inicio` once per point, captures `resultado`/`overflow` on each `pronto` rising edge, and buffers them in a small FIFO.
- Results leave on a valid/ready stream, so a slow consumer throttles the sweep without losing points.

Parameters:
- PROF, 4, result FIFO depth in entries; power of two, ≥2.
- LARG, 16, data width; matches the core's operand and result width.
- LIMITE_ESPERA, 1023, max cycles to wait for core `pronto` before aborting the sweep.

Ports:
- ck  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_start  in  1  one-cycle request to begin a sweep; honoured only when idle
- x_ini  in  LARG  first X value
- x_passo  in  LARG  X increment per point
- n_pontos  in  LARG  number of points; 0 means an empty sweep
- coef_a / coef_b / coef_c  in  LARG  coefficients, latched at cfg_start
- inicio_o  out  1  start pulse to core
- x_o / a_o / b_o / c_o  out  LARG  operands to core
- pronto_i  in  1  core done flag
- overflow_i  in  1  core overflow flag
- resultado_i  in  LARG  core result
- saida_valid  out  1  FIFO head valid
- saida_ready  in  1  consumer accepts head
- saida_dado  out  LARG  result
- saida_ovf  out  1  overflow flag of this result
- saida_ult  out  1  marks last point of the sweep
- ocupado  out  1  sweep in progress
- erro_timeout  out  1  sticky; set when the core never answered

Behaviour:
- Reset:
  - FSM goes to OCIOSO; FIFO is emptied.
  - All outputs are 0: `inicio_o`, `x_o`/`a_o`/`b_o`/`c_o`, `saida_*`, `ocupado`, `erro_timeout`.
  - Reset mid-sweep discards queued results and leaves the core unstarted; the core shares `rst`.
- Configuration:
  - `cfg_start` in OCIOSO latches `x_ini`/`x_passo`/`n_pontos`/`coef_*`, clears `erro_timeout`, and sets the remaining-point counter to `n_pontos`.
  - `cfg_start` in any other state is ignored.
  - `n_pontos`=0: return to OCIOSO the next cycle; nothing is pushed to the FIFO; `ocupado` is high for exactly 1 cycle.
- FSM states:
  - OCIOSO → DISPARO on accepted `cfg_start` when `n_pontos` ≠ 0.
  - DISPARO: waits until the FIFO has a free slot, counting entries still in flight. Then asserts `inicio_o` for exactly 1 cycle with `x_o` = current X and goes to ESPERA.
  - ESPERA: `x_o`/`a_o`/`b_o`/`c_o` are held stable. A rising edge of `pronto_i` (`pronto_i`=1 and registered previous value = 0) pushes {`resultado_i`, `overflow_i`, ult = (remaining == 1)} into the FIFO in that same cycle.
  - On that push, X ← X + `x_passo` (mod 2^LARG, wrap silently) and remaining decrements. Next state is OCIOSO if remaining was 1, else DISPARO.
  - ESPERA watchdog: a counter starts at 0 on entry. If it reaches LIMITE_ESPERA with no edge, set `erro_timeout`, push nothing, and go to OCIOSO.
- `ocupado` = 1 in every state except OCIOSO.
- Latency: the first `inicio_o` occurs 1 cycle after `cfg_start` when the FIFO is empty. A result is visible on `saida_valid` the cycle after its `pronto_i` edge.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address, for full/empty detection.
  - Pop happens on `saida_valid` & `saida_ready`.
  - A simultaneous push and pop on a full FIFO is never required, because DISPARO reserves the slot. Push and pop in the same cycle on a non-empty, non-full FIFO keeps the count unchanged.
  - `saida_dado`/`saida_ovf`/`saida_ult` are undefined-but-stable while `saida_valid`=0. They are driven from the head entry.
- At most one point is in flight in the core; no pipelining across points.
- `pronto_i` already high when entering ESPERA is not an edge. The block waits for it to fall, then rise.

Decomposition:
- Shared package holds:
  - the FSM state encoding: OCIOSO, DISPARO, ESPERA;
  - the LARG default;
  - the FIFO entry record type {dado, ovf, ult}.
- One sub-module, `fila_resultados` (sync FIFO: push/pop/cheia/vazia/contagem, parameter PROF), instantiated once.
- Sequencing FSM, X accumulator and watchdog stay in the top module.

Test Plan:
- A=1, B=2, C=3, x_ini=0, passo=1, n=3, ready held 1, core model = A·X²+B·X+C: stream 3, 6, 11 (X=0, 1, 2); ult only on 11; exactly 3 `inicio_o` pulses; `ocupado` falls after the third push.
- n=6, PROF=4, `saida_ready`=0 until 200 cycles: exactly 4 `inicio_o` pulses, then the FSM stalls in DISPARO. Raising ready drains the FIFO and resumes; 6 results arrive in order with no loss or duplication.
- x_ini=0xFFFE, passo=1, n=4, A=B=0, C=5: `x_o` sequence FFFE, FFFF, 0000, 0001; all results 5, ovf=0.
- Core model forces overflow on the 2nd point: `saida_ovf` = 0, 1, 0 for n=3.
- Core never raises `pronto_i`: after LIMITE_ESPERA cycles `erro_timeout`=1, `ocupado`=0, FIFO empty. A new `cfg_start` clears `erro_timeout`.
- `rst` pulsed mid-ESPERA with 2 queued results: next cycle `saida_valid`=0, `ocupado`=0, `inicio_o`=0. `cfg_start` during a running sweep leaves the sweep unaffected. n=0 produces no `inicio_o`.

Source files
------------

// File: rtl/varredura_polinomio_pkg.sv
// Shared types for the polynomial sweep sequencer: FSM states and result FIFO entry.
// Width default matches the polynomial core operand/result width.
package varredura_polinomio_pkg;

  localparam int LARG_PADRAO = 16;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DISPARO = 2'd1,
    ESPERA  = 2'd2
  } estado_t;

  typedef struct packed {
    logic [LARG_PADRAO-1:0] dado;
    logic                   ovf;
    logic                   ult;
  } entrada_t;

endpackage

// File: rtl/varredura_polinomio_fila.sv
// Synchronous result FIFO: circular buffer with pointers one bit wider than the address.
// Head entry is read combinationally so a push is visible on the very next cycle.
module fila_resultados
  import varredura_polinomio_pkg::*;
#(
  parameter int  PROF = 4,
  parameter type T    = entrada_t
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    push,
  input  T                        dado_in,
  input  logic                    pop,
  output T                        dado_out,
  output logic                    cheia,
  output logic                    vazia,
  output logic [$clog2(PROF):0]   contagem
);

  localparam int AW = $clog2(PROF);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  T            mem_q [PROF];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !cheia) wr_d = wr_q + (AW+1)'(1);
    if (pop && !vazia)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge ck) begin
    if (push && !cheia) mem_q[wr_q[AW-1:0]] <= dado_in;
  end

  assign vazia    = (wr_q == rd_q);
  assign cheia    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign contagem = wr_q - rd_q;
  assign dado_out = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/varredura_polinomio.sv
// Sweep sequencer for the polynomial core: launches one point at a time, collects each
// result on the rising edge of pronto_i and streams it out through a small FIFO.
module varredura_polinomio
  import varredura_polinomio_pkg::*;
#(
  parameter int PROF          = 4,
  parameter int LARG          = LARG_PADRAO,
  parameter int LIMITE_ESPERA = 1023
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [LARG-1:0] x_ini,
  input  logic [LARG-1:0] x_passo,
  input  logic [LARG-1:0] n_pontos,
  input  logic [LARG-1:0] coef_a,
  input  logic [LARG-1:0] coef_b,
  input  logic [LARG-1:0] coef_c,
  output logic            inicio_o,
  output logic [LARG-1:0] x_o,
  output logic [LARG-1:0] a_o,
  output logic [LARG-1:0] b_o,
  output logic [LARG-1:0] c_o,
  input  logic            pronto_i,
  input  logic            overflow_i,
  input  logic [LARG-1:0] resultado_i,
  output logic            saida_valid,
  input  logic            saida_ready,
  output logic [LARG-1:0] saida_dado,
  output logic            saida_ovf,
  output logic            saida_ult,
  output logic            ocupado,
  output logic            erro_timeout
);

  localparam int CW = $clog2(LIMITE_ESPERA + 1);
  localparam int FW = $clog2(PROF) + 1;

  estado_t         estado_q, estado_d;
  logic [LARG-1:0] x_q, x_d;
  logic [LARG-1:0] passo_q, passo_d;
  logic [LARG-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [LARG-1:0] resta_q, resta_d;
  logic [CW-1:0]   espera_q, espera_d;
  logic            pronto_ant_q, pronto_ant_d;
  logic            erro_q, erro_d;

  logic            borda;
  logic            push;
  logic            inicio;
  entrada_t        entrada;
  entrada_t        cabeca;
  logic            fila_cheia;
  logic            fila_vazia;
  logic [FW-1:0]   fila_contagem;

  assign borda        = pronto_i & ~pronto_ant_q;
  assign entrada.dado = resultado_i;
  assign entrada.ovf  = overflow_i;
  assign entrada.ult  = (resta_q == LARG'(1));

  always_comb begin
    estado_d     = estado_q;
    x_d          = x_q;
    passo_d      = passo_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    resta_d      = resta_q;
    espera_d     = espera_q;
    erro_d       = erro_q;
    pronto_ant_d = pronto_i;
    push         = 1'b0;
    inicio       = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (cfg_start) begin
          x_d      = x_ini;
          passo_d  = x_passo;
          a_d      = coef_a;
          b_d      = coef_b;
          c_d      = coef_c;
          resta_d  = n_pontos;
          erro_d   = 1'b0;
          // An empty sweep still spends one cycle here so ocupado pulses once.
          estado_d = DISPARO;
        end
      end
      DISPARO: begin
        if (resta_q == '0) begin
          estado_d = OCIOSO;
        end else if (fila_contagem < FW'(PROF)) begin
          inicio   = 1'b1;
          espera_d = '0;
          estado_d = ESPERA;
        end
      end
      ESPERA: begin
        if (borda) begin
          push     = ~fila_cheia;
          x_d      = x_q + passo_q;
          resta_d  = resta_q - LARG'(1);
          estado_d = (resta_q == LARG'(1)) ? OCIOSO : DISPARO;
        end else if (espera_q == CW'(LIMITE_ESPERA)) begin
          erro_d   = 1'b1;
          estado_d = OCIOSO;
        end else begin
          espera_d = espera_q + CW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      estado_q     <= OCIOSO;
      x_q          <= '0;
      passo_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      resta_q      <= '0;
      espera_q     <= '0;
      erro_q       <= 1'b0;
      pronto_ant_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      x_q          <= x_d;
      passo_q      <= passo_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      resta_q      <= resta_d;
      espera_q     <= espera_d;
      erro_q       <= erro_d;
      pronto_ant_q <= pronto_ant_d;
    end
  end

  fila_resultados #(
    .PROF (PROF),
    .T    (entrada_t)
  ) u_fila (
    .ck       (ck),
    .rst      (rst),
    .push     (push),
    .dado_in  (entrada),
    .pop      (saida_valid & saida_ready),
    .dado_out (cabeca),
    .cheia    (fila_cheia),
    .vazia    (fila_vazia),
    .contagem (fila_contagem)
  );

  // Head fields are forced to zero while empty so they read 0 out of reset.
  assign saida_valid  = ~fila_vazia;
  assign saida_dado   = saida_valid ? cabeca.dado : '0;
  assign saida_ovf    = saida_valid & cabeca.ovf;
  assign saida_ult    = saida_valid & cabeca.ult;

  assign inicio_o     = inicio;
  assign x_o          = x_q;
  assign a_o          = a_q;
  assign b_o          = b_q;
  assign c_o          = c_q;
  assign ocupado      = (estado_q != OCIOSO);
  assign erro_timeout = erro_q;

endmodule

// File: tb/tb_varredura_polinomio.sv
// Directed bench for varredura_polinomio with a behavioural polynomial core and stream collector.
module tb_varredura_polinomio;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [15:0] x_ini = '0, x_passo = '0, n_pontos = '0;
  logic [15:0] coef_a = '0, coef_b = '0, coef_c = '0;
  logic        inicio_o;
  logic [15:0] x_o, a_o, b_o, c_o;
  logic        pronto_i = 1'b0;
  logic        overflow_i = 1'b0;
  logic [15:0] resultado_i = '0;
  logic        saida_valid;
  logic        saida_ready = 1'b1;
  logic [15:0] saida_dado;
  logic        saida_ovf, saida_ult;
  logic        ocupado, erro_timeout;

  int n_vec = 0;
  int n_err = 0;

  varredura_polinomio #(.PROF(4), .LARG(16), .LIMITE_ESPERA(1023)) dut (
    .ck(ck), .rst(rst), .cfg_start(cfg_start),
    .x_ini(x_ini), .x_passo(x_passo), .n_pontos(n_pontos),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .inicio_o(inicio_o), .x_o(x_o), .a_o(a_o), .b_o(b_o), .c_o(c_o),
    .pronto_i(pronto_i), .overflow_i(overflow_i), .resultado_i(resultado_i),
    .saida_valid(saida_valid), .saida_ready(saida_ready),
    .saida_dado(saida_dado), .saida_ovf(saida_ovf), .saida_ult(saida_ult),
    .ocupado(ocupado), .erro_timeout(erro_timeout)
  );

  always #5 ck = ~ck;

  // Behavioural core: A*X^2+B*X+C a few cycles after inicio_o, pronto held until next start.
  int          inicio_cnt = 0;
  int          ovf_pt = 0;
  bit          mute = 1'b0;
  bit          busy = 1'b0;
  int          dly = 0;
  logic [15:0] xs, as_, bs, cs;
  logic [15:0] xlog[$];

  always @(negedge ck) begin
    if (rst) begin
      pronto_i = 1'b0;
      busy     = 1'b0;
    end else if (inicio_o) begin
      inicio_cnt++;
      xlog.push_back(x_o);
      xs = x_o; as_ = a_o; bs = b_o; cs = c_o;
      pronto_i = 1'b0;
      busy     = !mute;
      dly      = 3;
    end else if (busy) begin
      if (dly > 0) dly--;
      else begin
        resultado_i = as_ * xs * xs + bs * xs + cs;
        overflow_i  = (inicio_cnt == ovf_pt);
        pronto_i    = 1'b1;
        busy        = 1'b0;
      end
    end
  end

  logic [15:0] gd[$];
  logic        go[$], gu[$];
  logic [15:0] ed[$];
  logic        eo[$], eu[$];

  always @(negedge ck) begin
    #2;
    if (!rst && saida_valid && saida_ready) begin
      gd.push_back(saida_dado);
      go.push_back(saida_ovf);
      gu.push_back(saida_ult);
      $display("out dado=%h ovf=%0b ult=%0b", saida_dado, saida_ovf, saida_ult);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic limpa();
    gd.delete(); go.delete(); gu.delete(); xlog.delete();
    inicio_cnt = 0;
  endtask

  task automatic inicia(input logic [15:0] x, input logic [15:0] p, input logic [15:0] n,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge ck);
    x_ini = x; x_passo = p; n_pontos = n; coef_a = a; coef_b = b; coef_c = c;
    cfg_start = 1'b1;
    @(negedge ck);
    cfg_start = 1'b0;
  endtask

  task automatic espera_ocioso(input string tag, input int limite);
    int k = 0;
    while (ocupado && k < limite) begin @(negedge ck); k++; end
    if (ocupado) begin
      n_vec++; n_err++;
      $error("FAIL %s: ocupado still 1 after %0d cycles, required 0", tag, limite);
    end
  endtask

  task automatic espera_vazio(input string tag, input int limite);
    int k = 0;
    while (saida_valid && k < limite) begin @(negedge ck); k++; end
    @(negedge ck);
    if (saida_valid) begin
      n_vec++; n_err++;
      $error("FAIL %s: saida_valid still 1 after %0d cycles, required 0", tag, limite);
    end
  endtask

  task automatic compara(input string tag);
    chk({tag, "_count"}, gd.size(), ed.size());
    for (int i = 0; i < ed.size(); i++) begin
      chk($sformatf("%s_dado%0d", tag, i), {16'h0, gd[i]}, {16'h0, ed[i]});
      chk($sformatf("%s_ovf%0d", tag, i), {31'h0, go[i]}, {31'h0, eo[i]});
      chk($sformatf("%s_ult%0d", tag, i), {31'h0, gu[i]}, {31'h0, eu[i]});
    end
  endtask

  initial begin
    repeat (3) @(negedge ck);
    rst = 1'b0;
    @(negedge ck);
    chk("rst_valid", saida_valid, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_inicio", inicio_o, 0);
    chk("rst_x", x_o, 0);
    chk("rst_a", a_o, 0);
    chk("rst_dado", saida_dado, 0);
    chk("rst_erro", erro_timeout, 0);

    // 1: x^2+2x+3 over X=0,1,2
    limpa();
    inicia(16'd0, 16'd1, 16'd3, 16'd1, 16'd2, 16'd3);
    chk("t1_lat_inicio", inicio_o, 1);
    chk("t1_ocupado", ocupado, 1);
    espera_ocioso("t1_idle", 200);
    espera_vazio("t1_drain", 50);
    ed = '{16'd3, 16'd6, 16'd11}; eo = '{0, 0, 0}; eu = '{0, 0, 1};
    compara("t1");
    chk("t1_inicios", inicio_cnt, 3);
    chk("t1_ocupado_fim", ocupado, 0);

    // 2: backpressure with 6 points and a 4-deep FIFO
    limpa();
    saida_ready = 1'b0;
    inicia(16'd10, 16'd3, 16'd6, 16'd0, 16'd1, 16'd0);
    repeat (200) @(negedge ck);
    chk("t2_inicios_stall", inicio_cnt, 4);
    chk("t2_ocupado_stall", ocupado, 1);
    chk("t2_inicio_stall", inicio_o, 0);
    chk("t2_valid_stall", saida_valid, 1);
    saida_ready = 1'b1;
    espera_ocioso("t2_idle", 300);
    espera_vazio("t2_drain", 50);
    ed = '{16'd10, 16'd13, 16'd16, 16'd19, 16'd22, 16'd25};
    eo = '{0, 0, 0, 0, 0, 0}; eu = '{0, 0, 0, 0, 0, 1};
    compara("t2");
    chk("t2_inicios", inicio_cnt, 6);

    // 3: X wraps past FFFF
    limpa();
    inicia(16'hFFFE, 16'd1, 16'd4, 16'd0, 16'd0, 16'd5);
    espera_ocioso("t3_idle", 200);
    espera_vazio("t3_drain", 50);
    ed = '{16'd5, 16'd5, 16'd5, 16'd5}; eo = '{0, 0, 0, 0}; eu = '{0, 0, 0, 1};
    compara("t3");
    chk("t3_nx", xlog.size(), 4);
    chk("t3_x0", {16'h0, xlog[0]}, 32'hFFFE);
    chk("t3_x1", {16'h0, xlog[1]}, 32'hFFFF);
    chk("t3_x2", {16'h0, xlog[2]}, 32'h0000);
    chk("t3_x3", {16'h0, xlog[3]}, 32'h0001);

    // 4: overflow flag on second point only
    limpa();
    ovf_pt = 2;
    inicia(16'd4, 16'd1, 16'd3, 16'd0, 16'd0, 16'd7);
    espera_ocioso("t4_idle", 200);
    espera_vazio("t4_drain", 50);
    ed = '{16'd7, 16'd7, 16'd7}; eo = '{0, 1, 0}; eu = '{0, 0, 1};
    compara("t4");
    ovf_pt = 0;

    // 5: core never answers
    limpa();
    mute = 1'b1;
    inicia(16'd0, 16'd1, 16'd2, 16'd1, 16'd1, 16'd1);
    repeat (1000) @(negedge ck);
    chk("t5_erro_cedo", erro_timeout, 0);
    chk("t5_ocupado_cedo", ocupado, 1);
    espera_ocioso("t5_idle", 200);
    chk("t5_erro", erro_timeout, 1);
    chk("t5_valid", saida_valid, 0);
    chk("t5_inicios", inicio_cnt, 1);
    mute = 1'b0;
    limpa();
    inicia(16'd2, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0);
    chk("t5_erro_limpo", erro_timeout, 0);
    espera_ocioso("t5b_idle", 200);
    espera_vazio("t5b_drain", 50);
    ed = '{16'd4}; eo = '{0}; eu = '{1};
    compara("t5b");

    // 6: reset during ESPERA with two queued results
    limpa();
    saida_ready = 1'b0;
    inicia(16'd1, 16'd1, 16'd5, 16'd0, 16'd1, 16'd0);
    for (int k = 0; k < 200 && inicio_cnt < 3; k++) @(negedge ck);
    chk("t6_terceiro", inicio_cnt, 3);
    @(negedge ck);
    chk("t6_valid_antes", saida_valid, 1);
    rst = 1'b1;
    @(negedge ck);
    chk("t6_valid", saida_valid, 0);
    chk("t6_ocupado", ocupado, 0);
    chk("t6_inicio", inicio_o, 0);
    rst = 1'b0;
    saida_ready = 1'b1;
    repeat (20) @(negedge ck);
    chk("t6_inicios", inicio_cnt, 3);
    chk("t6_saidas", gd.size(), 0);

    // 7: cfg_start while busy is ignored
    limpa();
    inicia(16'd100, 16'd1, 16'd3, 16'd0, 16'd1, 16'd0);
    repeat (3) @(negedge ck);
    x_ini = 16'd500; n_pontos = 16'd1; cfg_start = 1'b1;
    @(negedge ck);
    cfg_start = 1'b0;
    espera_ocioso("t7_idle", 200);
    espera_vazio("t7_drain", 50);
    ed = '{16'd100, 16'd101, 16'd102}; eo = '{0, 0, 0}; eu = '{0, 0, 1};
    compara("t7");
    chk("t7_inicios", inicio_cnt, 3);

    // 8: empty sweep
    limpa();
    inicia(16'd0, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1);
    chk("t8_ocupado", ocupado, 1);
    chk("t8_inicio", inicio_o, 0);
    @(negedge ck);
    chk("t8_ocupado_fim", ocupado, 0);
    repeat (5) @(negedge ck);
    chk("t8_inicios", inicio_cnt, 0);
    chk("t8_valid", saida_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
